// File: rtl/csr_pkg.sv
// Shared CSR definitions: address map, op encodings, mstatus bit positions.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // funct3[1:0] selects the op; funct3[2] only picks reg vs zimm source,
  // which is already resolved upstream into csr_src.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  // Result of decoding one CSR address.
  typedef struct packed {
    logic        known;
    logic        ro;
    logic [31:0] val;
  } csr_rd_t;

  function automatic logic [31:0] csr_wval(csr_op_e op, logic [31:0] old, logic [31:0] src);
    case (op)
      OP_RW:   return src;
      OP_RS:   return old | src;
      OP_RC:   return old & ~src;
      default: return old;
    endcase
  endfunction

endpackage

// File: rtl/csr_if.sv
// CSR access bus between the writeback stage and the CSR file.
interface csr_if #(
  parameter int XLEN = 32
);
  logic            csr_en;
  logic [11:0]     csr_addr;
  logic [2:0]      csr_funct3;
  logic [XLEN-1:0] csr_src;
  logic            csr_src_zero;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  modport master (
    output csr_en, csr_addr, csr_funct3, csr_src, csr_src_zero,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_en, csr_addr, csr_funct3, csr_src, csr_src_zero,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/csr_counter.sv
// CNT_W-bit free-running counter with independent low/high word writes.
module csr_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] cnt
);
  localparam int HW = CNT_W - 32;

  // A half write replaces only that half and eats this cycle's increment.
  always_ff @(posedge clk) begin
    if (reset)      cnt <= '0;
    else if (wr_lo) cnt[31:0] <= wdata;
    else if (wr_hi) cnt[CNT_W-1:32] <= wdata[HW-1:0];
    else if (inc)   cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: architectural state, CSR ops, counters, trap/mret.
module csr_file
  import csr_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              CNT_W     = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = '0,
  parameter int              HART_ID   = 0
) (
  input  logic            clk,
  input  logic            reset,
  csr_if.slave            bus,
  input  logic            instr_retire,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic            mret,
  output logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] mepc_out
);

  logic             mie, mpie;
  logic [XLEN-1:2]  mtvec_base, mepc_hi;
  logic [XLEN-1:0]  mscratch, mcause;
  logic [CNT_W-1:0] mcycle, minstret;
  logic [XLEN-1:0]  mstatus_v, cyc_hi, ins_hi, wval;
  csr_rd_t          rsel;
  csr_op_e          op;
  logic             is_wr, illegal, wr;
  logic             unused_f3;

  assign op        = csr_op_e'(bus.csr_funct3[1:0]);
  assign unused_f3 = bus.csr_funct3[2];

  assign cyc_hi = XLEN'(mcycle[CNT_W-1:32]);
  assign ins_hi = XLEN'(minstret[CNT_W-1:32]);

  // Only MIE/MPIE exist in mstatus; everything else reads zero.
  always_comb begin
    mstatus_v               = '0;
    mstatus_v[MSTATUS_MIE]  = mie;
    mstatus_v[MSTATUS_MPIE] = mpie;
  end

  // Address decode: read value, implemented flag, read-only flag.
  always_comb begin
    rsel = '{known: 1'b1, ro: 1'b0, val: '0};
    case (bus.csr_addr)
      CSR_MSTATUS:   rsel.val = mstatus_v;
      CSR_MTVEC:     rsel.val = {mtvec_base, 2'b00};
      CSR_MSCRATCH:  rsel.val = mscratch;
      CSR_MEPC:      rsel.val = {mepc_hi, 2'b00};
      CSR_MCAUSE:    rsel.val = mcause;
      CSR_MCYCLE:    rsel.val = mcycle[31:0];
      CSR_MCYCLEH:   rsel.val = cyc_hi;
      CSR_MINSTRET:  rsel.val = minstret[31:0];
      CSR_MINSTRETH: rsel.val = ins_hi;
      CSR_CYCLE:     begin rsel.val = mcycle[31:0];   rsel.ro = 1'b1; end
      CSR_CYCLEH:    begin rsel.val = cyc_hi;         rsel.ro = 1'b1; end
      CSR_INSTRET:   begin rsel.val = minstret[31:0]; rsel.ro = 1'b1; end
      CSR_INSTRETH:  begin rsel.val = ins_hi;         rsel.ro = 1'b1; end
      CSR_MHARTID:   begin rsel.val = XLEN'(HART_ID); rsel.ro = 1'b1; end
      default:       rsel.known = 1'b0;
    endcase
  end

  // RS/RC with a zero source are pure reads, so they never count as writes.
  assign is_wr   = (op == OP_RW) || ((op == OP_RS || op == OP_RC) && !bus.csr_src_zero);
  assign illegal = bus.csr_en && (!rsel.known || (rsel.ro && is_wr));
  assign wr      = bus.csr_en && !illegal && is_wr && !trap_valid;
  assign wval    = csr_wval(op, rsel.val, bus.csr_src);

  assign bus.csr_rdata   = rsel.val;
  assign bus.csr_illegal = illegal;
  assign trap_target     = {mtvec_base, 2'b00};
  assign mepc_out        = {mepc_hi, 2'b00};

  // mstatus: trap beats mret beats a CSR write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mie  <= 1'b0;
      mpie <= 1'b0;
    end else if (trap_valid) begin
      mpie <= mie;
      mie  <= 1'b0;
    end else if (mret) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (wr && bus.csr_addr == CSR_MSTATUS) begin
      mie  <= wval[MSTATUS_MIE];
      mpie <= wval[MSTATUS_MPIE];
    end
  end

  // Trap-related and scratch registers; trap entry overrides CSR writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtvec_base <= MTVEC_RST[XLEN-1:2];
      mscratch   <= '0;
      mepc_hi    <= '0;
      mcause     <= '0;
    end else begin
      if (trap_valid) begin
        mepc_hi <= trap_pc[XLEN-1:2];
        mcause  <= trap_cause;
      end else begin
        if (wr && bus.csr_addr == CSR_MEPC)   mepc_hi <= wval[XLEN-1:2];
        if (wr && bus.csr_addr == CSR_MCAUSE) mcause  <= wval;
      end
      if (wr && bus.csr_addr == CSR_MTVEC)    mtvec_base <= wval[XLEN-1:2];
      if (wr && bus.csr_addr == CSR_MSCRATCH) mscratch   <= wval;
    end
  end

  csr_counter #(.CNT_W(CNT_W)) u_mcycle (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .wr_lo (wr && bus.csr_addr == CSR_MCYCLE),
    .wr_hi (wr && bus.csr_addr == CSR_MCYCLEH),
    .wdata (wval),
    .cnt   (mcycle)
  );

  csr_counter #(.CNT_W(CNT_W)) u_minstret (
    .clk   (clk),
    .reset (reset),
    .inc   (instr_retire),
    .wr_lo (wr && bus.csr_addr == CSR_MINSTRET),
    .wr_hi (wr && bus.csr_addr == CSR_MINSTRETH),
    .wdata (wval),
    .cnt   (minstret)
  );

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file; drives on negedge, samples before next posedge.
module tb_csr_file;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            instr_retire, trap_valid, mret;
  logic [XLEN-1:0] trap_pc, trap_cause, trap_target, mepc_out;
  int              n_chk = 0, n_err = 0;

  csr_if #(.XLEN(XLEN)) bus ();

  csr_file #(
    .XLEN(XLEN), .CNT_W(64), .MTVEC_RST(32'h0000_0100), .HART_ID(5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .instr_retire (instr_retire),
    .trap_valid   (trap_valid),
    .trap_pc      (trap_pc),
    .trap_cause   (trap_cause),
    .mret         (mret),
    .trap_target  (trap_target),
    .mepc_out     (mepc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.csr_en = 1'b0; bus.csr_addr = 12'h000; bus.csr_funct3 = 3'b000;
    bus.csr_src = '0; bus.csr_src_zero = 1'b0;
    instr_retire = 1'b0; trap_valid = 1'b0; mret = 1'b0;
    trap_pc = '0; trap_cause = '0;
  endtask

  task automatic op(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] s, input logic z);
    bus.csr_en = 1'b1; bus.csr_addr = a; bus.csr_funct3 = f3;
    bus.csr_src = s; bus.csr_src_zero = z;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    bus.csr_en = 1'b0; bus.csr_addr = a;
    #1 chk(tag, bus.csr_rdata, exp);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    rd(12'hB00, 32'd0, "rst_mcycle");
    rd(12'hB80, 32'd0, "rst_mcycleh");
    rd(12'h305, 32'h100, "rst_mtvec");
    rd(12'h300, 32'h0, "rst_mstatus");
    chk("rst_trap_target", trap_target, 32'h100);
    chk("rst_mepc_out", mepc_out, 32'h0);
    repeat (10) @(negedge clk);
    rd(12'hB00, 32'd10, "mcycle_10");

    // minstret counts only retiring cycles
    instr_retire = 1'b1;
    repeat (3) @(negedge clk);
    instr_retire = 1'b0;
    @(negedge clk);
    rd(12'hB02, 32'd3, "minstret_3");
    rd(12'hC02, 32'd3, "instret_mirror");

    // RW / RS / RC chain on mscratch
    op(12'h340, 3'b001, 32'hDEADBEEF, 1'b0);
    #1 chk("rw_old", bus.csr_rdata, 32'h0);
    chk("rw_legal", {31'b0, bus.csr_illegal}, 32'h0);
    @(negedge clk);
    op(12'h340, 3'b010, 32'h0000_0010, 1'b0);
    #1 chk("rs_old", bus.csr_rdata, 32'hDEADBEEF);
    @(negedge clk);
    op(12'h340, 3'b011, 32'h0000_000F, 1'b0);
    #1 chk("rc_old", bus.csr_rdata, 32'hDEADBEFF);
    @(negedge clk);
    rd(12'h340, 32'hDEADBEF0, "mscratch_final");

    // mcycle low write, carry into high, then high write holds low
    op(12'hB00, 3'b001, 32'hFFFF_FFFE, 1'b0);
    @(negedge clk);
    bus.csr_en = 1'b0;
    repeat (3) @(negedge clk);
    rd(12'hB00, 32'h1, "mcycle_wrap_lo");
    rd(12'hB80, 32'h1, "mcycle_wrap_hi");
    op(12'hB80, 3'b001, 32'h5, 1'b0);
    @(negedge clk);
    rd(12'hB00, 32'h1, "mcycle_lo_held");
    rd(12'hB80, 32'h5, "mcycle_hi_wr");
    rd(12'hC80, 32'h5, "cycleh_mirror");
    rd(12'hB00, 32'h1, "mcycle_lo_same_cyc");

    // mtvec low bits forced to zero
    op(12'h305, 3'b001, 32'h0000_1003, 1'b0);
    @(negedge clk);
    rd(12'h305, 32'h1000, "mtvec_align");
    chk("trap_target", trap_target, 32'h1000);

    // MIE via CSRRSI, then trap racing a mscratch write
    op(12'h300, 3'b110, 32'h8, 1'b0);
    @(negedge clk);
    rd(12'h300, 32'h8, "mstatus_mie");
    op(12'h340, 3'b001, 32'h1234_5678, 1'b0);
    trap_valid = 1'b1; trap_pc = 32'h104; trap_cause = 32'h2;
    @(negedge clk);
    trap_valid = 1'b0;
    rd(12'h341, 32'h104, "trap_mepc");
    rd(12'h342, 32'h2, "trap_mcause");
    rd(12'h300, 32'h80, "trap_mstatus");
    rd(12'h340, 32'hDEADBEF0, "trap_drops_wr");
    chk("mepc_out", mepc_out, 32'h104);
    mret = 1'b1;
    @(negedge clk);
    mret = 1'b0;
    rd(12'h300, 32'h88, "mret_mstatus");

    // unaligned trap pc, then mret beating a CSRRCI on mstatus
    trap_valid = 1'b1; trap_pc = 32'h207; trap_cause = 32'h8000_000B;
    @(negedge clk);
    trap_valid = 1'b0;
    rd(12'h341, 32'h204, "trap_pc_align");
    rd(12'h342, 32'h8000_000B, "trap_cause2");
    rd(12'h300, 32'h80, "trap2_mstatus");
    op(12'h300, 3'b111, 32'h88, 1'b0);
    mret = 1'b1;
    @(negedge clk);
    mret = 1'b0;
    rd(12'h300, 32'h88, "mret_beats_wr");
    op(12'h341, 3'b001, 32'h333, 1'b0);
    @(negedge clk);
    rd(12'h341, 32'h330, "mepc_wr_align");

    // read-only and unimplemented accesses
    op(12'hF14, 3'b001, 32'hFF, 1'b0);
    #1 chk("hartid_rw_ill", {31'b0, bus.csr_illegal}, 32'h1);
    chk("hartid_val", bus.csr_rdata, 32'h5);
    @(negedge clk);
    op(12'hF14, 3'b010, 32'h0, 1'b1);
    #1 chk("hartid_rs0_legal", {31'b0, bus.csr_illegal}, 32'h0);
    op(12'h7C0, 3'b001, 32'h1, 1'b0);
    #1 chk("unimpl_ill", {31'b0, bus.csr_illegal}, 32'h1);
    chk("unimpl_rdata", bus.csr_rdata, 32'h0);
    @(negedge clk);
    op(12'hC80, 3'b001, 32'h77, 1'b0);
    #1 chk("cycleh_rw_ill", {31'b0, bus.csr_illegal}, 32'h1);
    @(negedge clk);
    rd(12'hB80, 32'h5, "ro_wr_no_effect");
    bus.csr_addr = 12'h7C0;
    #1 chk("unimpl_no_en", {31'b0, bus.csr_illegal}, 32'h0);

    // reset overrides a simultaneous write and trap
    @(negedge clk);
    op(12'h340, 3'b001, 32'hAAAA_AAAA, 1'b0);
    trap_valid = 1'b1; trap_pc = 32'h500; trap_cause = 32'h7;
    reset = 1'b1;
    @(negedge clk);
    trap_valid = 1'b0;
    rd(12'h340, 32'h0, "rst2_mscratch");
    rd(12'h341, 32'h0, "rst2_mepc");
    rd(12'h342, 32'h0, "rst2_mcause");
    rd(12'h300, 32'h0, "rst2_mstatus");
    @(negedge clk);
    rd(12'h305, 32'h100, "rst2_mtvec");
    rd(12'hB00, 32'h0, "rst2_mcycle");
    rd(12'hB80, 32'h0, "rst2_mcycleh");
    rd(12'hB02, 32'h0, "rst2_minstret");
    chk("rst2_trap_target", trap_target, 32'h100);
    chk("rst2_mepc_out", mepc_out, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    rd(12'hB00, 32'h1, "post_rst_mcycle");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
Machine-mode CSR register file for the pipelined RV32 core. Successor to the decode-only CSR write detection: it holds architectural CSR state, executes CSRRW/CSRRS/CSRRC (and immediate forms), runs free-running cycle/instret counters of parametrised width, and performs trap entry and mret state updates. Reads are issued from the writeback stage. Trap and mret requests come from the hazard/exception logic.

Parameters:
XLEN, 32, data width of CSR read/write ports; only 32 supported in this generation
CNT_W, 64, width of mcycle/minstret; legal 33..64; high half exposed via *h CSRs, zero-extended to XLEN
MTVEC_RST, 32'h0000_0000, reset value of mtvec (must be 4-byte aligned)
HART_ID, 0, value returned by mhartid

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
csr_en  in  1  CSR instruction valid in writeback this cycle
csr_addr  in  12  CSR address, instr[31:20]
csr_funct3  in  3  instr[14:12]; 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
csr_src  in  XLEN  rs1 value, or zero-extended zimm for the immediate forms
csr_src_zero  in  1  rs1 field / zimm == 0; suppresses the write for RS/RC
csr_rdata  out  XLEN  old CSR value; combinational from csr_addr
csr_illegal  out  1  access to an unimplemented CSR, or write to a read-only CSR
instr_retire  in  1  one instruction retired this cycle
trap_valid  in  1  take a trap this cycle
trap_pc  in  XLEN  PC of the faulting instruction
trap_cause  in  XLEN  mcause value
mret  in  1  mret retiring this cycle
trap_target  out  XLEN  {mtvec[XLEN-1:2],2'b00}
mepc_out  out  XLEN  current mepc, the mret redirect target

Behaviour:
- Reset (sync, active-high; overrides everything that cycle): mstatus.MIE=0, MPIE=0; mtvec=MTVEC_RST; mscratch=0; mepc=0; mcause=0; mcycle=0; minstret=0. Outputs settle to csr_rdata=value at csr_addr, csr_illegal per address, trap_target=MTVEC_RST, mepc_out=0.
- Address map: 0x300 mstatus (bits 3 MIE and 7 MPIE writable, others read 0); 0x305 mtvec (bits[1:0] read 0, direct mode only); 0x340 mscratch; 0x341 mepc (bits[1:0] forced 0); 0x342 mcause; 0xB00/0xB80 mcycle lo/hi; 0xB02/0xB82 minstret lo/hi; 0xC00/0xC80/0xC02/0xC82 read-only mirrors; 0xF14 mhartid (read-only).
- Read: combinational, zero latency. Unknown address gives rdata=0 and csr_illegal=1 whenever csr_en=1.
- Write value: RW gives src; RS gives old|src; RC gives old&~src. Committed at the clk edge when csr_en=1 and not illegal. RS/RC with csr_src_zero=1 perform no write and are legal even on read-only CSRs. RW to a read-only CSR is illegal, and state is unchanged.
- Counters: mcycle increments every cycle; minstret increments when instr_retire=1. Both wrap mod 2^CNT_W. A CSR write to a half replaces that half with the written value and suppresses the increment that cycle. The other half is held, with no carry. Writes to high-half bits at or above CNT_W-32 are dropped.
- Trap entry (trap_valid=1): mepc<=trap_pc&~3; mcause<=trap_cause; MPIE<=MIE; MIE<=0. Takes priority over a simultaneous csr_en write, which is dropped. Counters still increment.
- mret: MIE<=MPIE; MPIE<=1. trap_valid and mret in the same cycle is illegal upstream; if it occurs, trap wins.
- Simultaneous csr write and mret to mstatus: mret wins.
- No internal stalls. One CSR op per cycle. Back-to-back ops see the prior write (the register is updated at the edge).

Decomposition:
- Shared package csr_pkg: CSR address localparams, funct3 op encodings, mstatus bit indices.
- One natural sub-module, csr_counter: CNT_W-bit counter with inc, write-low and write-high, instantiated twice (mcycle, minstret).

Test Plan:
- Reset, then 10 idle cycles, then read 0xB00 -> 10 (cycle 0 reads 0). 0xB80 reads 0. mtvec reads MTVEC_RST.
- CSRRW 0x340 src=0xDEADBEEF, then CSRRS src=0x0000_0010, then CSRRC src=0xF -> rdata sequence 0, 0xDEADBEEF, 0xDEADBEFF. Final mscratch=0xDEADBEF0.
- Write mcycle lo=0xFFFF_FFFE, idle 3 cycles -> lo reads 0x1, hi reads 0x1. Write hi=0x5 -> that cycle lo is held, hi=5.
- Set MIE via CSRRSI 0x300 zimm=8, then trap_valid with pc=0x104 and cause=2 in the same cycle as a CSRRW to mscratch -> mepc=0x104, mcause=2, mstatus=0x80, mscratch unchanged. Then mret -> mstatus=0x88.
- CSRRW 0xF14 -> csr_illegal=1, rdata=HART_ID. CSRRS 0xF14 with src_zero=1 -> illegal=0. Access 0x7C0 -> illegal=1, rdata=0.
- Assert reset mid-sequence with csr_en and trap_valid high -> all state returns to reset values next cycle.
